// File: rtl/sprite_compositor_if.sv
// Pixel bus between the sprite generators / game logic and the compositor.
// The game side drives layer data and mask writes; the compositor drives
// the resolved pixel and the per-frame collision report.
interface sprite_compositor_if #(
    parameter int NUM_LAYERS = 4,
    parameter int RGB_W      = 12
);
    logic                        disp_i;
    logic                        frame_start_i;
    logic [NUM_LAYERS*RGB_W-1:0] layer_rgb_i;
    logic [NUM_LAYERS-1:0]       layer_alpha_i;
    logic                        mask_wr_i;
    logic [NUM_LAYERS-1:0]       mask_i;
    logic [RGB_W-1:0]            rgb_o;
    logic                        disp_o;
    logic [NUM_LAYERS-1:0]       coll_o;
    logic                        coll_valid_o;

    modport master (
        output disp_i, frame_start_i, layer_rgb_i, layer_alpha_i, mask_wr_i, mask_i,
        input  rgb_o, disp_o, coll_o, coll_valid_o
    );

    modport slave (
        input  disp_i, frame_start_i, layer_rgb_i, layer_alpha_i, mask_wr_i, mask_i,
        output rgb_o, disp_o, coll_o, coll_valid_o
    );
endinterface

// File: rtl/sprite_compositor.sv
// N-layer fixed-priority sprite compositor with a frame-synchronous layer
// enable mask and per-frame overlap (collision) reporting.
// Two-stage pipeline: stage 1 registers inputs and the masked alpha,
// stage 2 resolves the lowest-index opaque layer over the background.
module sprite_compositor #(
    parameter int               NUM_LAYERS = 4,
    parameter int               RGB_W      = 12,
    parameter logic [RGB_W-1:0] BG_COLOR   = 12'h000
) (
    input  logic                clk,
    input  logic                rst,
    sprite_compositor_if.slave  bus
);
    logic [NUM_LAYERS*RGB_W-1:0] s1_rgb;
    logic                        s1_disp;
    logic [NUM_LAYERS-1:0]       s1_alpha;

    logic [NUM_LAYERS-1:0]       pending_mask;
    logic [NUM_LAYERS-1:0]       active_mask;

    logic [NUM_LAYERS-1:0]       acc;
    logic [NUM_LAYERS-1:0]       acc_next;
    logic                        overlap;

    logic [RGB_W-1:0]            pick_rgb;
    logic [RGB_W-1:0]            rgb_q;
    logic                        disp_q;
    logic [NUM_LAYERS-1:0]       coll_q;
    logic                        coll_valid_q;

    assign bus.rgb_o        = rgb_q;
    assign bus.disp_o       = disp_q;
    assign bus.coll_o       = coll_q;
    assign bus.coll_valid_o = coll_valid_q;

    // Mask staging: writes land in pending, which only becomes active at a
    // frame boundary; a write coinciding with the boundary takes effect at once.
    always_ff @(posedge clk) begin
        if (!rst) begin
            pending_mask <= '1;
            active_mask  <= '1;
        end else begin
            if (bus.mask_wr_i)
                pending_mask <= bus.mask_i;
            if (bus.frame_start_i)
                active_mask <= bus.mask_wr_i ? bus.mask_i : pending_mask;
        end
    end

    // Stage 1: register layer data with the enable mask already applied.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_rgb   <= '0;
            s1_disp  <= 1'b0;
            s1_alpha <= '0;
        end else begin
            s1_rgb   <= bus.layer_rgb_i;
            s1_disp  <= bus.disp_i;
            s1_alpha <= bus.layer_alpha_i & active_mask;
        end
    end

    // Priority pick: scan high to low so the lowest opaque index wins.
    always_comb begin
        pick_rgb = BG_COLOR;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (s1_alpha[k])
                pick_rgb = s1_rgb[k*RGB_W +: RGB_W];
        end
    end

    // Two or more effective layers opaque means overlap; a & (a-1) clears the
    // lowest set bit, so it is nonzero exactly when at least two bits are set.
    always_comb begin
        overlap  = s1_disp && ((s1_alpha & (s1_alpha - NUM_LAYERS'(1))) != '0);
        acc_next = overlap ? (acc | s1_alpha) : acc;
    end

    // Stage 2: output pixel, blanked outside the visible area.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rgb_q  <= '0;
            disp_q <= 1'b0;
        end else begin
            rgb_q  <= s1_disp ? pick_rgb : '0;
            disp_q <= s1_disp;
        end
    end

    // Collision accumulator: report and clear at each frame boundary.
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc          <= '0;
            coll_q       <= '0;
            coll_valid_q <= 1'b0;
        end else begin
            coll_valid_q <= bus.frame_start_i;
            if (bus.frame_start_i) begin
                coll_q <= acc_next;
                acc    <= '0;
            end else begin
                acc    <= acc_next;
            end
        end
    end
endmodule

// File: tb/tb_sprite_compositor.sv
// Directed bench for sprite_compositor: priority, blanking, mask timing,
// collision reporting, masked collision, back-to-back frames, mid-frame reset.
module tb_sprite_compositor;
    localparam int NL = 4;
    localparam int RW = 12;
    localparam logic [RW-1:0] BG = 12'h00F;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    sprite_compositor_if #(.NUM_LAYERS(NL), .RGB_W(RW)) bus ();

    sprite_compositor #(.NUM_LAYERS(NL), .RGB_W(RW), .BG_COLOR(BG)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input logic d, input logic [NL-1:0] a);
        bus.disp_i        = d;
        bus.layer_alpha_i = a;
    endtask

    task automatic frame();
        bus.frame_start_i = 1'b1;
        step();
        bus.frame_start_i = 1'b0;
    endtask

    initial begin
        // layers 3..0
        bus.layer_rgb_i   = {12'h0F0, 12'h222, 12'hF00, 12'h111};
        bus.disp_i        = 1'b0;
        bus.frame_start_i = 1'b0;
        bus.layer_alpha_i = '0;
        bus.mask_wr_i     = 1'b0;
        bus.mask_i        = '0;

        // reset state
        step(); step();
        chk("rst_rgb", 32'(bus.rgb_o), 32'h0);
        chk("rst_disp", 32'(bus.disp_o), 32'h0);
        chk("rst_coll", 32'(bus.coll_o), 32'h0);
        chk("rst_cvalid", 32'(bus.coll_valid_o), 32'h0);
        rst = 1'b1;

        // priority: alpha 1010 -> layer1 wins
        pix(1'b1, 4'b1010); step(); step();
        chk("prio_rgb", 32'(bus.rgb_o), 32'hF00);
        chk("prio_disp", 32'(bus.disp_o), 32'h1);
        pix(1'b1, 4'b0000); step(); step();
        chk("bg_rgb", 32'(bus.rgb_o), 32'(BG));

        // blanking: fully opaque but invisible
        pix(1'b0, 4'b1111); step(); step();
        chk("blank_rgb", 32'(bus.rgb_o), 32'h0);
        chk("blank_disp", 32'(bus.disp_o), 32'h0);
        pix(1'b0, 4'b0000);
        frame();
        chk("blank_coll", 32'(bus.coll_o), 32'hA);
        chk("blank_cvalid", 32'(bus.coll_valid_o), 32'h1);
        step();
        chk("cvalid_pulse", 32'(bus.coll_valid_o), 32'h0);

        // collision report
        pix(1'b1, 4'b0101); step();
        pix(1'b0, 4'b0000); step(); step();
        frame();
        chk("coll_0101", 32'(bus.coll_o), 32'h5);
        chk("coll_0101_v", 32'(bus.coll_valid_o), 32'h1);
        step();
        chk("coll_hold", 32'(bus.coll_o), 32'h5);
        chk("coll_hold_v", 32'(bus.coll_valid_o), 32'h0);
        pix(1'b1, 4'b0001); step(); step();
        pix(1'b0, 4'b0000); step(); step();
        frame();
        chk("coll_none", 32'(bus.coll_o), 32'h0);

        // mask timing: mid-frame write waits for frame_start
        pix(1'b1, 4'b1010);
        bus.mask_wr_i = 1'b1; bus.mask_i = 4'b1101;
        step();
        bus.mask_wr_i = 1'b0;
        step();
        chk("mask_pend1", 32'(bus.rgb_o), 32'hF00);
        step();
        chk("mask_pend2", 32'(bus.rgb_o), 32'hF00);
        pix(1'b0, 4'b0000); step(); step();
        frame();
        chk("mask_coll", 32'(bus.coll_o), 32'hA);
        pix(1'b1, 4'b1010); step(); step();
        chk("mask_apply", 32'(bus.rgb_o), 32'h0F0);

        // coincident write and frame_start
        pix(1'b0, 4'b0000); step(); step();
        bus.mask_wr_i = 1'b1; bus.mask_i = 4'b0111;
        frame();
        bus.mask_wr_i = 1'b0;
        pix(1'b1, 4'b1010); step(); step();
        chk("mask_coinc", 32'(bus.rgb_o), 32'hF00);
        pix(1'b0, 4'b0000); step(); step();
        frame();
        pix(1'b1, 4'b1010); step(); step();
        chk("mask_coinc_pend", 32'(bus.rgb_o), 32'hF00);

        // masked collision with active mask 1110
        pix(1'b0, 4'b0000); step(); step();
        bus.mask_wr_i = 1'b1; bus.mask_i = 4'b1110;
        frame();
        bus.mask_wr_i = 1'b0;
        pix(1'b1, 4'b0011); step();
        pix(1'b0, 4'b0000); step();
        chk("masked_rgb", 32'(bus.rgb_o), 32'hF00);
        step();
        frame();
        chk("masked_coll", 32'(bus.coll_o), 32'h0);

        // back-to-back frame_start
        pix(1'b1, 4'b0110); step();
        pix(1'b0, 4'b0000); step(); step();
        bus.frame_start_i = 1'b1;
        step();
        chk("b2b_first", 32'(bus.coll_o), 32'h6);
        step();
        bus.frame_start_i = 1'b0;
        chk("b2b_second", 32'(bus.coll_o), 32'h0);
        chk("b2b_second_v", 32'(bus.coll_valid_o), 32'h1);

        // reset mid-frame
        pix(1'b1, 4'b1110); step(); step();
        rst = 1'b0; step();
        chk("mrst_rgb", 32'(bus.rgb_o), 32'h0);
        chk("mrst_disp", 32'(bus.disp_o), 32'h0);
        chk("mrst_coll", 32'(bus.coll_o), 32'h0);
        chk("mrst_cvalid", 32'(bus.coll_valid_o), 32'h0);
        rst = 1'b1;
        pix(1'b0, 4'b0000); step(); step();
        frame();
        chk("mrst_fcoll", 32'(bus.coll_o), 32'h0);
        chk("mrst_fcvalid", 32'(bus.coll_valid_o), 32'h1);
        pix(1'b1, 4'b0001); step(); step();
        chk("mrst_mask_l0", 32'(bus.rgb_o), 32'h111);
        pix(1'b1, 4'b0011); step();
        pix(1'b0, 4'b0000); step(); step();
        frame();
        chk("mrst_mask_coll", 32'(bus.coll_o), 32'h3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised N-layer pixel compositor for the PlaneWar display path. It sits between the sprite generators (player, enemies, bullets, HUD) and the VGA output stage, all running on the pixel clock. Each cycle it resolves per-layer RGB/alpha into one pixel by fixed priority over a background colour. It also applies a frame-synchronous layer-enable mask and reports per-frame sprite overlap (collision) flags to game logic.

## Interface
- `NUM_LAYERS`, default 4: number of sprite layers. Legal range is 1..8. Layer 0 has the highest priority.
- `RGB_W`, default 12: packed pixel width (R,G,B concatenated, matching the codebase RGB depth).
- `BG_COLOR`, default 12'h000: colour shown where no enabled layer is opaque.

Ports:
- `clk` in 1: pixel clock (40 MHz). This is the only clock.
- `rst` in 1: synchronous, active-low reset. It is sampled on the rising edge of `clk`.
- `disp_i` in 1: high while the current pixel is inside the visible area.
- `frame_start_i` in 1: single-cycle pulse once per frame. It is issued during blanking, at least 2 cycles after the last `disp_i` high.
- `layer_rgb_i` in NUM_LAYERS*RGB_W: layer k occupies bits [k*RGB_W +: RGB_W].
- `layer_alpha_i` in NUM_LAYERS: bit k=1 means layer k is opaque at this pixel.
- `mask_wr_i` in 1: write strobe for the pending enable mask.
- `mask_i` in NUM_LAYERS: new enable mask. Bit k=1 enables layer k.
- `rgb_o` out RGB_W: composited pixel.
- `disp_o` out 1: `disp_i` delayed to align with `rgb_o`.
- `coll_o` out NUM_LAYERS: collision mask for the previous frame. It holds its value between frames.
- `coll_valid_o` out 1: 1-cycle pulse when `coll_o` updates.

## Operation
- **Stage 1 (register):**
  - Capture `layer_rgb_i` and `disp_i`.
  - Capture `eff_alpha = layer_alpha_i & active_mask`.
- **Stage 2 (resolve):**
  - If stage-1 disp is 0, `rgb_o` = 0.
  - Otherwise `rgb_o` is the rgb of the lowest-index layer k with `eff_alpha[k]`=1.
  - If no layer is opaque, `rgb_o` = BG_COLOR.
  - `disp_o` <= stage-1 disp.
- **Mask registers:**
  - `pending_mask` <= `mask_i` on `mask_wr_i`.
  - `active_mask` <= `pending_mask` on `frame_start_i`.
  - Simultaneous `mask_wr_i` and `frame_start_i`: `active_mask` and `pending_mask` both load `mask_i` directly. The write is not lost and not delayed one frame.
  - The mask never changes mid-frame.
- **Collision accumulator `acc` (NUM_LAYERS bits):**
  - Contribution is evaluated on stage-1 data.
  - If stage-1 disp=1 and popcount(`eff_alpha`) >= 2, then `acc_next = acc | eff_alpha`; otherwise `acc_next = acc`.
  - Masked layers never contribute.
  - Popcount saturates logically; only the >=2 test matters.
- **Frame boundary (`frame_start_i`=1):**
  - `coll_o` <= `acc_next`.
  - `coll_valid_o` <= 1 for exactly one cycle.
  - `acc` <= 0.
  - On all other cycles, `acc` <= `acc_next`.
- **NUM_LAYERS=1:** `coll_o` is always 0.

## Timing
- **Latency:** 2 cycles from `layer_*_i`/`disp_i` to `rgb_o`/`disp_o`. Throughput is 1 pixel per cycle, with no stalls.
- **Mask effect:** a mask written during frame N is applied to pixels presented on or after the cycle following the frame_start that ends frame N.
- **`coll_o`/`coll_valid_o`:** update on the clock edge at which `frame_start_i` is sampled high. `coll_valid_o` is high during the following cycle only.
- **Reset (`rst`=0 at a clock edge):**
  - `rgb_o`=0, `disp_o`=0, `coll_o`=0, `coll_valid_o`=0.
  - `acc`=0.
  - `active_mask` and `pending_mask` = all ones.
  - Stage-1 registers = 0.
  - Reset asserted mid-frame discards the pipeline and the partial collision data. The first `frame_start_i` after reset reports only post-reset overlaps.
- **Back-to-back `frame_start_i`:** the second pulse reports `acc_next` from the intervening cycle, normally 0, with a fresh `coll_valid_o` pulse.

## Test plan
- **Priority:**
  - Stimulus: NUM_LAYERS=4, `disp_i`=1, alpha=4'b1010, layer1 rgb=12'hF00, layer3 rgb=12'h0F0.
  - Response: `rgb_o`=12'hF00 two cycles later; `disp_o`=1.
  - Stimulus: alpha=0.
  - Response: `rgb_o`=BG_COLOR.
- **Blanking:**
  - Stimulus: `disp_i`=0 with alpha=4'b1111.
  - Response: `rgb_o`=0, `disp_o`=0, and no collision accumulated.
- **Mask timing:**
  - Stimulus: write `mask_i`=4'b1101 mid-frame, with layer1 opaque at 12'hF00 and layer3 opaque at 12'h0F0.
  - Response: `rgb_o` stays 12'hF00 until frame_start, then becomes 12'h0F0.
  - Stimulus: write coincident with frame_start.
  - Response: the new mask is effective immediately after that edge.
- **Collision report:**
  - Stimulus: one visible pixel with alpha=4'b0101, then frame_start.
  - Response: `coll_o`=4'b0101 with a 1-cycle `coll_valid_o`.
  - Stimulus: next frame has no overlap.
  - Response: `coll_o`=4'b0000 at the next frame_start.
- **Masked collision:**
  - Stimulus: active_mask=4'b1110, alpha=4'b0011, then frame_start.
  - Response: `coll_o`=0, because the single effective layer gives no overlap.
- **Reset mid-frame:**
  - Stimulus: accumulate overlaps, assert `rst`=0 for 1 cycle, release, then frame_start.
  - Response: all outputs are 0 during reset; `coll_o`=0 after frame_start; mask has returned to all ones.
